// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequencer for an external DSP slice that computes unsigned 18x18
// dot products over packets of operand pairs.
//
// Each accepted pair goes to the slice A/B inputs. The slice accumulates the
// products in its P register under OPMODE control from this block. The LAST
// pair of a packet starts a drain. After the drain, the P output is captured
// and presented as the result, together with the beat count.
//
// Ports
//   clk, rst_n           clock shared with the slice; synchronous active-low reset
//   s_valid/s_ready      operand-stream handshake
//   s_a, s_b, s_last     unsigned operand pair and end-of-packet marker
//   dsp_a, dsp_b         registered slice A/B inputs
//   dsp_opmode           registered slice OPMODE, aligned with the product
//   dsp_rstp             slice P-register reset (follows !rst_n combinationally)
//   dsp_p                slice P output
//   r_valid/r_ready      result handshake
//   r_data               accumulated dot product (mod 2^48)
//   r_count              beats in the packet, saturating at 255
module dsp_mac_seq #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_last,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_rstp,
  input  logic [47:0] dsp_p,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [47:0] r_data,
  output logic [7:0]  r_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [7:0] OP_FIRST = 8'h01;  // P = M
  localparam logic [7:0] OP_ACC   = 8'h09;  // P = P + M
  localparam logic [7:0] OP_HOLD  = 8'h08;  // P = P

  // The drain ends once the last product has reached P and been settled for a
  // cycle. That is MUL_LAT+2 edges after LAST is accepted.
  localparam logic [2:0] DRAIN_LAST = 3'(MUL_LAT + 1);

  state_t     state;
  logic [2:0] drain_cnt;
  logic       accept;
  logic [7:0] op_code;

  // op_pipe[0] is in step with dsp_a/dsp_b. Each further stage adds one cycle
  // of multiplier latency, so the last stage lines up with the product at the
  // post-adder.
  logic [7:0] op_pipe [0:MUL_LAT];

  always_comb begin
    s_ready = rst_n && ((state == IDLE) || (state == ACCUM));
    accept  = s_valid && s_ready;
    op_code = OP_HOLD;
    if (accept) begin
      op_code = (state == IDLE) ? OP_FIRST : OP_ACC;
    end
  end

  assign dsp_rstp   = ~rst_n;
  assign dsp_opmode = op_pipe[MUL_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      r_data    <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      for (int unsigned i = 0; i <= MUL_LAT; i++) begin
        op_pipe[i] <= OP_HOLD;
      end
    end else begin
      op_pipe[0] <= op_code;
      for (int unsigned i = 1; i <= MUL_LAT; i++) begin
        op_pipe[i] <= op_pipe[i-1];
      end

      if (accept) begin
        dsp_a <= s_a;
        dsp_b <= s_b;
        if (state == IDLE) begin
          r_count <= 8'd1;
        end else if (r_count != 8'hFF) begin
          r_count <= r_count + 8'd1;
        end
      end

      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            state     <= s_last ? DRAIN : ACCUM;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state   <= HOLD;
            r_valid <= 1'b1;
            r_data  <= dsp_p;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        HOLD: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: self-checking bench for dsp_mac_seq.
//
// A behavioural DSP slice closes the loop. It has an A1/B1 register, a
// combinational multiplier and a P register with the X/Z muxes decoded from
// OPMODE. The stimulus side keeps an arithmetic reference: the sum of products
// mod 2^48 and a saturating beat count. It pushes the expected result of each
// packet when LAST is accepted. A negedge monitor checks each result against
// that queue at the result handshake. It also checks the per-cycle OPMODE
// sequence, the result latency, the result stability under backpressure, and
// the reset values.
module tb_dsp_mac_seq;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [17:0] s_a = '0;
  logic [17:0] s_b = '0;
  logic        s_last = 1'b0;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [47:0] r_data;
  logic [7:0]  r_count;

  dsp_mac_seq #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_rstp(dsp_rstp),
    .dsp_p(dsp_p),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_count(r_count)
  );

  always #5 clk = ~clk;

  // Behavioural slice: product delayed LAT cycles, P = Z + X.
  logic [35:0]      mcur, mprod;
  logic [2:0][35:0] mdly = '0;
  logic [47:0]      preg = '0, xsel, zsel;

  always_comb begin
    mcur = 36'(dsp_a) * 36'(dsp_b);
    case (LAT)
      0:       mprod = mcur;
      1:       mprod = mdly[0];
      2:       mprod = mdly[1];
      default: mprod = mdly[2];
    endcase
    xsel = (dsp_opmode[1:0] == 2'b01) ? {12'd0, mprod} : 48'd0;
    zsel = (dsp_opmode[3:2] == 2'b10) ? preg : 48'd0;
  end

  always @(posedge clk) begin
    if (dsp_rstp) begin
      preg <= '0;
      mdly <= '0;
    end else begin
      mdly <= {mdly[1:0], mcur};
      preg <= zsel + xsel;
    end
  end
  assign dsp_p = preg;

  // Scoreboard and counters.
  typedef struct packed {
    logic [47:0] d;
    logic [7:0]  c;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model state, driven from the stimulus side.
  logic [47:0] m_sum = '0;
  int          m_cnt = 0;
  bit          m_in_pkt = 1'b0;

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int n = 0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fail_now("send_timeout");
      s_valid = 1'b0;
      s_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!m_in_pkt) begin
      m_sum = '0;
      m_cnt = 0;
    end
    m_sum = m_sum + 48'(a) * 48'(b);
    m_cnt++;
    m_in_pkt = !last;
    if (last) q.push_back({m_sum, (m_cnt > 255) ? 8'd255 : 8'(m_cnt)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!r_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!r_valid) fail_now("wait_rvalid");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) fail_now("wait_drain");
  endtask

  // r_ready driver: 0 = always ready, 1 = random, 2 = held low.
  int rr_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'b0;
      endcase
    end
  end

  // Monitor.
  int   cyc = 0;
  bit   rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  logic [7:0]  hist[$];
  bit          hold_prev = 1'b0, acc_prev = 1'b0, rv_prev = 1'b0, mon_in_pkt = 1'b0;
  logic [47:0] pd = '0;
  logic [7:0]  pc = '0;
  int          last_acc = 0;

  always @(negedge clk) begin
    logic [7:0] code;
    exp_t       e;
    if (rst_at_edge) begin
      check("rst_dsp_a", 64'(dsp_a), 64'd0);
      check("rst_dsp_b", 64'(dsp_b), 64'd0);
      check("rst_r_data", 64'(r_data), 64'd0);
      check("rst_r_count", 64'(r_count), 64'd0);
      check("rst_r_valid", 64'(r_valid), 64'd0);
      check("rst_opmode", 64'(dsp_opmode), 64'h08);
    end
    if (!rst_n) begin
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_dsp_rstp", 64'(dsp_rstp), 64'd1);
      hold_prev  = 1'b0;
      acc_prev   = 1'b0;
      rv_prev    = 1'b0;
      mon_in_pkt = 1'b0;
      hist.delete();
      repeat (LAT + 1) hist.push_back(8'h08);
    end else begin
      check("opmode_seq", 64'(dsp_opmode), 64'(hist[LAT]));
      if (hold_prev) begin
        check("hold_r_valid", 64'(r_valid), 64'd1);
        check("hold_r_data", 64'(r_data), 64'(pd));
        check("hold_r_count", 64'(r_count), 64'(pc));
      end
      if (acc_prev) check("r_valid_drop", 64'(r_valid), 64'd0);
      if (r_valid) check("s_ready_busy", 64'(s_ready), 64'd0);
      if (r_valid && !rv_prev) check("latency", 64'(cyc - last_acc), 64'(LAT + 3));
      if (r_valid && r_ready) begin
        if (q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = q.pop_front();
          check("r_data", 64'(r_data), 64'(e.d));
          check("r_count", 64'(r_count), 64'(e.c));
        end
      end
      code = 8'h08;
      if (s_valid && s_ready) begin
        code = mon_in_pkt ? 8'h09 : 8'h01;
        if (s_last) begin
          last_acc   = cyc;
          mon_in_pkt = 1'b0;
        end else begin
          mon_in_pkt = 1'b1;
        end
      end
      hist.push_front(code);
      void'(hist.pop_back());
      hold_prev = r_valid && !r_ready;
      acc_prev  = r_valid && r_ready;
      rv_prev   = r_valid;
      pd        = r_data;
      pc        = r_count;
    end
  end

  // Stimulus.
  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back packet: 2*3 + 4*5 + 6*7 = 68, 3 beats.
    send(18'd2, 18'd3, 1'b0);
    send(18'd4, 18'd5, 1'b0);
    send(18'd6, 18'd7, 1'b1);
    wait_drain();

    // Single full-scale beat.
    send(18'h3FFFF, 18'h3FFFF, 1'b1);
    wait_drain();

    // Backpressure in HOLD, then a fresh packet with no residue.
    rr_mode = 2;
    send(18'd5, 18'd6, 1'b1);
    wait_rvalid();
    idle(5);
    rr_mode = 0;
    wait_drain();
    send(18'd1, 18'd1, 1'b1);
    wait_drain();

    // Gaps inside a packet.
    send(18'd10, 18'd10, 1'b0);
    idle(3);
    send(18'd1, 18'd2, 1'b1);
    wait_drain();

    // Reset mid-packet discards the partial sum.
    send(18'd100, 18'd100, 1'b0);
    rst_n = 1'b0;
    m_in_pkt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(18'd3, 18'd3, 1'b1);
    wait_drain();

    // Count saturation.
    for (int i = 0; i < 300; i++) send(18'd1, 18'd1, (i == 299));
    wait_drain();

    // Random packets with random gaps and random result backpressure.
    rr_mode = 1;
    repeat (40) begin
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        send(18'($urandom), 18'($urandom), (j == len - 1));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    wait_drain();
    rr_mode = 0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 Parameter MUL_LAT, default 1, SHALL give the cycles from DSP_A/DSP_B presented to the product at the slice post-adder; legal range 0..3.
REQ-003 CLK  input  1  rising-edge clock shared with the DSP slice.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 S_VALID/S_READY  input/output  1/1  operand-stream handshake.
REQ-006 S_A, S_B  input  18 each  unsigned operand pair.
REQ-007 S_LAST  input  1  marks the final pair of a packet.
REQ-008 DSP_A, DSP_B  output  18 each  slice A/B inputs (registered).
REQ-009 DSP_OPMODE  output  8  slice OPMODE (registered).
REQ-010 DSP_RSTP  output  1  slice P-register reset; SHALL equal !RST_N combinationally.
REQ-011 DSP_P  input  48  slice P output.
REQ-012 R_VALID/R_READY  output/input  1/1  result handshake.
REQ-013 R_DATA  output  48  accumulated dot product.
REQ-014 R_COUNT  output  8  beats in the packet, saturating at 255.

Function
REQ-015 Target slice configuration: A1REG=B1REG=1, A0REG=B0REG=0, MREG=0, PREG=1, OPMODEREG=0, CARRYINSEL="OPMODE5", B_INPUT="DIRECT", all CEs high. MUL_LAT=1 for this configuration.
REQ-016 States:
  - IDLE: awaiting the first beat.
  - ACCUM: packet in progress.
  - DRAIN: pipeline flushing.
  - HOLD: result presented.
REQ-017 S_READY SHALL be 1 in IDLE and ACCUM, and 0 in DRAIN, in HOLD, and in any cycle with RST_N=0.
REQ-018 On an accepted beat, DSP_A<=S_A and DSP_B<=S_B. Otherwise DSP_A and DSP_B hold their values.
REQ-019 OPMODE code per cycle:
  - First beat of a packet (accepted in IDLE): 0x01 (X=M, Z=0).
  - Later beats (accepted in ACCUM): 0x09 (X=M, Z=P).
  - Cycles with no accepted beat: 0x08 (Z=P, X=0, hold).
  - OPMODE[7:4] SHALL always be 0.
REQ-020 The OPMODE code SHALL pass through an internal MUL_LAT-deep delay line, reset-filled with 0x08, before driving DSP_OPMODE. It is therefore aligned with the product, not with DSP_A/DSP_B.
REQ-021 Transitions:
  - IDLE -> ACCUM on an accepted beat with S_LAST=0.
  - IDLE or ACCUM -> DRAIN on an accepted beat with S_LAST=1.
  - DRAIN -> HOLD after MUL_LAT+1 cycles.
  - HOLD -> IDLE on R_VALID&R_READY.
REQ-022 Timing: LAST is accepted at edge e0. At edge e0+MUL_LAT+2, R_DATA<=DSP_P, R_VALID<=1, and the state enters HOLD.
REQ-023 In HOLD, R_DATA and R_COUNT SHALL be stable until the handshake. R_VALID SHALL deassert at the edge on which it is accepted.
REQ-024 Arithmetic is unsigned 18x18 into 36 bits, zero-extended and summed modulo 2^48. No carry-in is used.
REQ-025 R_COUNT:
  - Cleared on the first beat, then incremented per accepted beat.
  - Saturates at 255.
  - The registered value SHALL include the LAST beat.
REQ-026 S_VALID gaps in ACCUM SHALL NOT alter the sum.

Reset
REQ-027 While RST_N=0 at an edge, the block SHALL set:
  - state to IDLE;
  - DSP_A, DSP_B, R_DATA, R_COUNT, R_VALID to 0;
  - DSP_OPMODE and the delay line to 0x08.
  An in-flight packet SHALL be discarded, and DSP_RSTP clears the slice P register.
REQ-028 Reset takes priority over every handshake in the same cycle.

Verification
REQ-029 Packet (2,3),(4,5),(6,7 LAST) back-to-back, MUL_LAT=1 -> R_DATA=68, R_COUNT=3, R_VALID exactly 3 cycles after the LAST accept.
REQ-030 Single beat (0x3FFFF,0x3FFFF,LAST) -> R_DATA=68718952449, R_COUNT=1. DSP_OPMODE is 0x01 for exactly one cycle.
REQ-031 Backpressure: hold R_READY=0 for 5 cycles in HOLD -> R_VALID=1 and R_DATA stable, S_READY=0. After acceptance, the next packet (1,1 LAST) -> R_DATA=1, with no residue from the prior sum.
REQ-032 Gaps: (10,10), three idle cycles, (1,2 LAST) -> DSP_OPMODE=0x08 during the gaps, R_DATA=102, R_COUNT=2.
REQ-033 Reset mid-ACCUM: after (100,100), RST_N=0 for one cycle, then (3,3 LAST) -> R_DATA=9, R_COUNT=1.
REQ-034 A 300-beat packet of (1,1) -> R_DATA=300, R_COUNT=255.
